// File: rtl/cu_sequencer.sv
// Hardwired control-unit sequencer: steps fetch/decode/operand/execute micro-states
// and emits one registered control word per state until HALT.
module cu_sequencer #(
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   data_to_cu,
  input  logic              acc_sign,
  output logic [CTRL_W-1:0] control_signal,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op
);

  localparam int unsigned B_MAR_PC  = 0;
  localparam int unsigned B_MBR_MEM = 1;
  localparam int unsigned B_PC_INC  = 2;
  localparam int unsigned B_MAR_MBR = 3;
  localparam int unsigned B_IR_MBR  = 4;
  localparam int unsigned B_MEM_MBR = 5;
  localparam int unsigned B_MBR_ACC = 6;
  localparam int unsigned B_ACC_MBR = 7;
  localparam int unsigned B_ACC_ADD = 8;
  localparam int unsigned B_ACC_SUB = 9;
  localparam int unsigned B_PC_MBR  = 10;
  localparam int unsigned B_IR_CU   = 13;

  localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STORE  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JMP    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMPGEZ = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(7);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_O0, S_O1, S_E0, S_E1, S_E2, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              illegal_q, illegal_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  // State, opcode and registered outputs all advance on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_F3;
      S_F3:   state_d = S_DEC;
      S_DEC: begin
        opcode_d = data_to_cu;
        if (data_to_cu == OP_NOP) begin
          state_d = S_F0;
        end else if (data_to_cu == OP_HALT) begin
          state_d = S_HALT;
        end else if (data_to_cu <= OP_JMPGEZ) begin
          state_d = S_O0;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_O0:   state_d = S_O1;
      S_O1:   state_d = S_E0;
      S_E0:   state_d = (opcode_q == OP_JMP || opcode_q == OP_JMPGEZ) ? S_F0 : S_E1;
      S_E1:   state_d = S_E2;
      S_E2:   state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Word for the state being entered; acc_sign is live while state_q is O1
  always_comb begin
    ctrl_d   = '0;
    busy_d   = !(state_d == S_IDLE || state_d == S_HALT);
    halted_d = (state_d == S_HALT);
    case (state_d)
      S_F0, S_O0: ctrl_d[B_MAR_PC] = 1'b1;
      S_F1, S_O1: begin
        ctrl_d[B_MBR_MEM] = 1'b1;
        ctrl_d[B_PC_INC]  = 1'b1;
      end
      S_F2: ctrl_d[B_IR_MBR] = 1'b1;
      S_F3: ctrl_d[B_IR_CU]  = 1'b1;
      S_E0: begin
        if (opcode_q == OP_JMP)         ctrl_d[B_PC_MBR]  = 1'b1;
        else if (opcode_q == OP_JMPGEZ) ctrl_d[B_PC_MBR]  = !acc_sign;
        else                            ctrl_d[B_MAR_MBR] = 1'b1;
      end
      S_E1: begin
        if (opcode_q == OP_STORE) ctrl_d[B_MBR_ACC] = 1'b1;
        else                      ctrl_d[B_MBR_MEM] = 1'b1;
      end
      S_E2: begin
        case (opcode_q)
          OP_LOAD:  ctrl_d[B_ACC_MBR] = 1'b1;
          OP_STORE: ctrl_d[B_MEM_MBR] = 1'b1;
          OP_ADD:   ctrl_d[B_ACC_ADD] = 1'b1;
          OP_SUB:   ctrl_d[B_ACC_SUB] = 1'b1;
          default:  ctrl_d = '0;
        endcase
      end
      default: ctrl_d = '0;
    endcase
  end

  assign control_signal = ctrl_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Randomized bench for cu_sequencer: plays the IR/ACC side and compares every
// cycle's control word and status against a per-opcode micro-op sequence model.
module tb_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  data_to_cu = 8'h00;
  logic        acc_sign = 1'b0;
  logic [31:0] control_signal;
  logic        busy, halted, illegal_op;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cu_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .data_to_cu     (data_to_cu),
    .acc_sign       (acc_sign),
    .control_signal (control_signal),
    .busy           (busy),
    .halted         (halted),
    .illegal_op     (illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] w,
                          input logic b, input logic h, input logic il);
    chk({tag, ".word"},    control_signal,     w);
    chk({tag, ".busy"},    32'(busy),          32'(b));
    chk({tag, ".halted"},  32'(halted),        32'(h));
    chk({tag, ".illegal"}, 32'(illegal_op),    32'(il));
  endtask

  // Expected word per cycle for one instruction, F0 through its last state
  function automatic void model_words(input logic [7:0] op, input bit sign);
    exp_q = {};
    exp_q.push_back(32'h001); exp_q.push_back(32'h006);
    exp_q.push_back(32'h010); exp_q.push_back(32'h2000);
    exp_q.push_back(32'h000);
    if (op >= 8'd1 && op <= 8'd6) begin
      exp_q.push_back(32'h001); exp_q.push_back(32'h006);
    end
    case (op)
      8'd1: begin exp_q.push_back(32'h008); exp_q.push_back(32'h002); exp_q.push_back(32'h080); end
      8'd2: begin exp_q.push_back(32'h008); exp_q.push_back(32'h040); exp_q.push_back(32'h020); end
      8'd3: begin exp_q.push_back(32'h008); exp_q.push_back(32'h002); exp_q.push_back(32'h100); end
      8'd4: begin exp_q.push_back(32'h008); exp_q.push_back(32'h002); exp_q.push_back(32'h200); end
      8'd5: exp_q.push_back(32'h400);
      8'd6: exp_q.push_back(sign ? 32'h000 : 32'h400);
      default: ;
    endcase
  endfunction

  // Runs one instruction; the IR side presents op only while it is valid
  task automatic run_instr(input logic [7:0] op, input int abort_at);
    bit sign;
    sign = 1'($urandom);
    model_words(op, sign);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      chk_outs($sformatf("op%02h.k%0d", op, k), exp_q[k], 1'b1, 1'b0, 1'b0);
      if (k == abort_at) break;
      start      = 1'($urandom);
      acc_sign   = (k == 6) ? sign : 1'($urandom);
      data_to_cu = (k == 3 || k == 4) ? op : 8'($urandom);
    end
  endtask

  task automatic halt_phase(input logic ill);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_outs($sformatf("halt%0d", i), 32'h0, 1'b0, 1'b1, ill);
      start = 1'($urandom);
    end
  endtask

  task automatic idle_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_outs($sformatf("idle%0d", i), 32'h0, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    #1 rst = 1'b0;
    #1 chk_outs("rst_now", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_phase(10);
    for (int e = 0; e < 6; e++) begin
      start = 1'b1;
      for (int i = 0; i < 15; i++) run_instr(8'($urandom_range(0, 6)), -1);
      case (e % 3)
        0: begin
          run_instr((e == 0) ? 8'h2A : 8'($urandom_range(8, 255)), -1);
          halt_phase(1'b1);
          do_reset();
        end
        1: begin
          run_instr(8'h07, -1);
          halt_phase(1'b0);
          do_reset();
        end
        default: begin
          run_instr(8'h02, 8);
          do_reset();
        end
      endcase
      idle_phase(3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
